// File: rtl/pkt_rx_buffer.sv
// ---------------------------------------------------------------------------
// pkt_rx_buffer
//   Receive-side buffer for the 49-bit network packet. It keeps packets whose
//   destination port equals PORT_ID, stores their 32-bit payload in a
//   first-word-fall-through FIFO and offers it on a ready/valid stream. It
//   returns one credit per consumed word, and reports overflow and
//   misrouted-packet counts.
//
// Ports
//   clk         in   1    system clock, rising edge
//   reset_n     in   1    asynchronous active-low reset
//   in_port     in   49   [48] vld, [47:43] dst_leaf (unused), [42:39] dst_port,
//                         [38:32] reserved, [31:0] payload
//   dout        out  32   payload at the FIFO head
//   dout_vld    out  1    dout holds valid data
//   dout_rdy    in   1    consumer accepts dout this cycle
//   credit_ret  out  1    registered one-cycle pulse per word popped
//   fill_level  out  AW+1 number of stored words, 0..DEPTH
//   overflow    out  1    sticky: a matching packet was dropped while full
//   drop_cnt    out  8    saturating count of valid, misrouted packets
// ---------------------------------------------------------------------------
module pkt_rx_buffer #(
    parameter int         DEPTH   = 16,
    parameter logic [3:0] PORT_ID = 4'd0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [48:0]              in_port,
    output logic [31:0]              dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic                     credit_ret,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;
    logic          r_credit;

    logic w_vld;
    logic w_port_hit;
    logic w_match;
    logic w_misroute;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_unused;

    // Leaf address and reserved field are not decoded at this stage.
    assign w_unused   = ^{in_port[47:43], in_port[38:32]};

    assign w_vld      = in_port[48];
    assign w_port_hit = (in_port[42:39] == PORT_ID);
    assign w_match    = w_vld && w_port_hit;
    assign w_misroute = w_vld && !w_port_hit;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = dout_vld && dout_rdy;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push     = w_match && (!w_full || w_pop);

    // dout_vld derives only from the reset-cleared count, so an unwritten
    // (X) memory word can never make the stream look valid.
    assign dout_vld   = (r_count != '0);
    assign dout       = r_mem[r_rd_ptr];
    assign fill_level = r_count;
    assign credit_ret = r_credit;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

    // Storage is intentionally left unreset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_port[31:0];
        end
    end

    // Pointers are AW bits wide so DEPTH (a power of two) wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
            r_credit   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_credit <= w_pop;
            if (w_match && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_misroute && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_rx_buffer.sv
module tb_pkt_rx_buffer;

    localparam int         DEPTH = 16;
    localparam logic [3:0] PID   = 4'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [48:0] in_port;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        credit_ret;
    logic [4:0]  fill_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    pkt_rx_buffer #(.DEPTH(DEPTH), .PORT_ID(PID)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_rdy   (dout_rdy),
        .credit_ret (credit_ret),
        .fill_level (fill_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the buffer is just an ordered list of accepted payloads.
    logic [31:0] q[$];
    bit          m_ovf;
    int          m_drop;
    bit          m_credit;
    int          credits_seen;
    int          words_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf    = 0;
        m_drop   = 0;
        m_credit = 0;
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic cycle(input logic v, input logic [3:0] port,
                         input logic [31:0] pay, input logic rdy);
        bit match, pop, push;
        in_port  = {v, 5'($urandom), port, 7'($urandom), pay};
        dout_rdy = rdy;
        @(negedge clk);
        chk("dout_vld", 32'(dout_vld), 32'(q.size() != 0));
        if (q.size() != 0) chk("dout", dout, q[0]);
        chk("fill_level", 32'(fill_level), 32'(q.size()));
        chk("credit_ret", 32'(credit_ret), 32'(m_credit));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (credit_ret === 1'b1) credits_seen++;
        match = v && (port == PID);
        pop   = (q.size() != 0) && rdy;
        push  = match && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            words_out++;
        end
        if (push) q.push_back(pay);
        if (match && !push) m_ovf = 1;
        if (v && (port != PID) && (m_drop < 255)) m_drop++;
        m_credit = pop;
    endtask

    task automatic do_reset();
        in_port  = '0;
        dout_rdy = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        chk("rst_dout_vld", 32'(dout_vld), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_credit", 32'(credit_ret), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        int sent, cyc;
        bit send;
        reset_n  = 1'b1;
        in_port  = '0;
        dout_rdy = 1'b0;
        model_clear();
        @(posedge clk);
        #1;

        // 1: single packet, one-cycle latency, credit one cycle after pop
        do_reset();
        repeat (3) cycle(1'b0, PID, 32'h0, 1'b1);
        cycle(1'b1, PID, 32'hDEADBEEF, 1'b1);
        chk("t1_vld", 32'(dout_vld), 32'd1);
        chk("t1_dout", dout, 32'hDEADBEEF);
        cycle(1'b0, PID, 32'h0, 1'b1);
        chk("t1_credit", 32'(credit_ret), 32'd1);
        cycle(1'b0, PID, 32'h0, 1'b1);
        chk("t1_fill", 32'(fill_level), 32'd0);

        // 2: fill to 16, overflow on the 17th, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, PID, 32'(i), 1'b0);
        cycle(1'b1, PID, 32'h99, 1'b0);
        chk("t2_fill", 32'(fill_level), 32'd16);
        chk("t2_ovf", 32'(overflow), 32'd1);
        credits_seen = 0;
        words_out    = 0;
        for (int i = 0; i < 18; i++) cycle(1'b0, PID, 32'h0, 1'b1);
        chk("t2_words", 32'(words_out), 32'd16);
        chk("t2_credits", 32'(credits_seen), 32'd16);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);

        // 3: full FIFO with simultaneous pop accepts the new word
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, PID, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, PID, 32'hA5, 1'b1);
        chk("t3_fill", 32'(fill_level), 32'd16);
        chk("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 18; i++) cycle(1'b0, PID, 32'h0, 1'b1);
        chk("t3_empty", 32'(fill_level), 32'd0);

        // 4: misrouted packets saturate drop_cnt; invalid packets are ignored
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, PID + 4'd1, $urandom, 1'($urandom));
        for (int i = 0; i < 3; i++) cycle(1'b0, PID, $urandom, 1'b1);
        chk("t4_drop", 32'(drop_cnt), 32'd255);
        chk("t4_fill", 32'(fill_level), 32'd0);

        // 5: randomized traffic under credit flow control, pointers wrap
        do_reset();
        credits_seen = 0;
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || q.size() != 0 || m_credit) && cyc < 3000) begin
            send = (sent < 40) && ((DEPTH - sent + credits_seen) > 0) &&
                   ($urandom_range(0, 3) != 0);
            cycle(send, PID, $urandom, 1'($urandom));
            if (send) sent++;
            cyc++;
        end
        chk("t5_sent", 32'(sent), 32'd40);
        chk("t5_credits", 32'(credits_seen), 32'd40);
        chk("t5_ovf", 32'(overflow), 32'd0);

        // 6: asynchronous reset mid-operation discards contents
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, PID, 32'hC0 + 32'(i), 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, PID, 32'h0, 1'b1);
        chk("t6_pre_fill", 32'(fill_level), 32'd5);
        chk("t6_pre_credit", 32'(credit_ret), 32'd1);
        chk("t6_pre_ovf", 32'(overflow), 32'd1);
        in_port  = '0;
        dout_rdy = 1'b0;
        #3;
        reset_n = 1'b0;
        #2;
        chk("t6_async_vld", 32'(dout_vld), 32'd0);
        chk("t6_async_fill", 32'(fill_level), 32'd0);
        chk("t6_async_ovf", 32'(overflow), 32'd0);
        chk("t6_async_credit", 32'(credit_ret), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        cycle(1'b1, PID, 32'h1234, 1'b0);
        chk("t6_new_vld", 32'(dout_vld), 32'd1);
        chk("t6_new_dout", dout, 32'h1234);
        chk("t6_new_fill", 32'(fill_level), 32'd1);
        cycle(1'b0, PID, 32'h0, 1'b1);
        cycle(1'b0, PID, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
